// File: rtl/asteroid_spawn_ctrl.sv
// asteroid_spawn_ctrl
// Per-asteroid control stage: produces the once-per-frame move strobe,
// counts down a respawn delay after the asteroid is destroyed, picks a
// pseudo-random spawn column from a free-running LFSR and re-arms the
// asteroid with a one-pixpulse unbreak strobe. It also keeps a saturating
// score and a speed level derived from the asteroid's inc_score flag.
module asteroid_spawn_ctrl #(
    parameter int unsigned XMIN           = 40,
    parameter int unsigned XMAX           = 600,
    parameter int unsigned FRAME_LINE     = 480,
    parameter int unsigned RESPAWN_FRAMES = 30,
    parameter logic [9:0]  LFSR_SEED      = 10'h2A5,
    parameter int unsigned PTS_PER_LEVEL  = 8,
    parameter int unsigned MAX_LEVEL      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       broken,
    input  logic       inc_score,
    input  logic       game_over,
    output logic       move,
    output logic       unbreak,
    output logic [9:0] spawn_x,
    output logic       spawn_valid,
    output logic [7:0] score,
    output logic [2:0] speed_level
);

    localparam logic [9:0] XMIN_V      = 10'(XMIN);
    localparam logic [9:0] XMAX_V      = 10'(XMAX);
    localparam logic [9:0] FRAME_V     = 10'(FRAME_LINE);
    localparam logic [7:0] RESPAWN_CNT = 8'(RESPAWN_FRAMES);
    localparam logic [7:0] PTS_V       = 8'(PTS_PER_LEVEL);
    localparam logic [2:0] MAX_LEVEL_V = 3'(MAX_LEVEL);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SPAWN  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [9:0] lfsr;
    logic       broken_d;
    logic       inc_d;

    logic       frame_tick;
    logic       broken_rise;
    logic       inc_rise;
    logic       lfsr_legal;
    logic [7:0] score_next;
    logic       level_up;

    // Event decode: frame tick, input edges, spawn legality, next score.
    always_comb begin
        frame_tick  = pixpulse && (hcount == 10'd0) && (vcount == FRAME_V) && !game_over;
        broken_rise = broken && !broken_d;
        inc_rise    = inc_score && !inc_d;
        lfsr_legal  = (lfsr >= XMIN_V) && (lfsr <= XMAX_V);
        score_next  = score + 8'd1;
        level_up    = ((score_next % PTS_V) == 8'd0);
    end

    // Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1), advances every clk.
    // NOTE: all clocked state uses non-blocking (<=) assignments so every
    // register samples pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    // Score and speed level, updated on rising edges of inc_score.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_d       <= 1'b0;
            score       <= 8'd0;
            speed_level <= 3'd0;
        end else if (pixpulse) begin
            inc_d <= inc_score;
            if (inc_rise && !game_over && (score != 8'hFF)) begin
                score <= score_next;
                if (level_up && (speed_level < MAX_LEVEL_V)) begin
                    speed_level <= speed_level + 3'd1;
                end
            end
        end
    end

    // Respawn FSM with registered move/unbreak strobes; each strobe is set on
    // one pixpulse cycle and cleared on the next, so the asteroid sees it once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_ACTIVE;
            cnt         <= 8'd0;
            broken_d    <= 1'b0;
            move        <= 1'b0;
            unbreak     <= 1'b0;
            spawn_valid <= 1'b0;
            spawn_x     <= XMIN_V;
        end else if (pixpulse) begin
            broken_d    <= broken;
            move        <= frame_tick;
            unbreak     <= 1'b0;
            spawn_valid <= 1'b0;
            if (!game_over) begin
                case (state)
                    ST_ACTIVE: begin
                        // A tick in the same cycle as the edge is not counted.
                        if (broken_rise) begin
                            cnt   <= RESPAWN_CNT;
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (frame_tick) begin
                            if (cnt <= 8'd1) begin
                                cnt   <= 8'd0;
                                state <= ST_SPAWN;
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                    end
                    ST_SPAWN: begin
                        // Out-of-range LFSR values are rejected; retry next pixpulse.
                        if (lfsr_legal) begin
                            spawn_x     <= lfsr;
                            unbreak     <= 1'b1;
                            spawn_valid <= 1'b1;
                            state       <= ST_ACTIVE;
                        end
                    end
                    default: state <= ST_ACTIVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_asteroid_spawn_ctrl.sv
// Directed testbench for asteroid_spawn_ctrl. A reduced VGA sweep
// (hcount 0..7, vcount 476..483, pixpulse every other clk) gives one frame
// tick per 64 pixpulses at hcount=0/vcount=480.
module tb_asteroid_spawn_ctrl;

    localparam int         RF    = 3;
    localparam logic [9:0] SEED  = 10'h2A5;
    localparam int         FLINE = 480;
    localparam int         XLO   = 40;
    localparam int         XHI   = 600;
    localparam int         HMAX  = 7;
    localparam int         VMIN  = 476;
    localparam int         VMAX  = 483;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount = 10'd0;
    logic [9:0] vcount = 10'(VMIN);
    logic       broken = 1'b0;
    logic       inc_score = 1'b0;
    logic       game_over = 1'b0;
    logic       move;
    logic       unbreak;
    logic [9:0] spawn_x;
    logic       spawn_valid;
    logic [7:0] score;
    logic [2:0] speed_level;

    always #5 clk = ~clk;

    asteroid_spawn_ctrl #(.RESPAWN_FRAMES(RF), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .broken(broken), .inc_score(inc_score), .game_over(game_over),
        .move(move), .unbreak(unbreak), .spawn_x(spawn_x), .spawn_valid(spawn_valid),
        .score(score), .speed_level(speed_level)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference expectations for the strobe path.
    logic [9:0] m_lfsr;
    int         m_st;
    int         m_cnt;
    logic       m_bd;
    logic       exp_move, exp_ub;
    logic [9:0] exp_x;
    // Observation statistics.
    int move_err, ub_err, x_err, pos_err, move_rises, move_hi, ub_pulses, retries;
    logic prev_move, prev_ub;
    logic [9:0] last_x;

    task automatic model_reset();
        m_lfsr = SEED; m_st = 0; m_cnt = 0; m_bd = 1'b0;
        exp_move = 1'b0; exp_ub = 1'b0; exp_x = 10'(XLO);
        prev_move = 1'b0; prev_ub = 1'b0;
    endtask

    task automatic clear_stats();
        move_err = 0; ub_err = 0; x_err = 0; pos_err = 0;
        move_rises = 0; move_hi = 0; ub_pulses = 0; retries = 0;
    endtask

    // One clk: update expectations at posedge, observe at negedge, then
    // advance the sweep and toggle pixpulse.
    task automatic step();
        logic       tick;
        logic [9:0] cand;
        @(posedge clk);
        tick = pixpulse && (hcount == 10'd0) && (vcount == 10'(FLINE)) && !game_over;
        cand = m_lfsr;
        if (!rst) begin
            model_reset();
        end else begin
            m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
            if (pixpulse) begin
                exp_move = tick;
                exp_ub   = 1'b0;
                if (!game_over) begin
                    if (m_st == 0) begin
                        if (broken && !m_bd) begin m_st = 1; m_cnt = RF; end
                    end else if (m_st == 1) begin
                        if (tick) begin m_cnt--; if (m_cnt == 0) m_st = 2; end
                    end else begin
                        if (cand >= 10'(XLO) && cand <= 10'(XHI)) begin
                            exp_ub = 1'b1; exp_x = cand; m_st = 0;
                        end else retries++;
                    end
                end
                m_bd = broken;
            end
        end
        @(negedge clk);
        if (move !== exp_move) move_err++;
        if (unbreak !== exp_ub || spawn_valid !== exp_ub) ub_err++;
        if (spawn_x !== exp_x) x_err++;
        if (move && !prev_move) begin
            move_rises++;
            if (!(hcount == 10'd0 && vcount == 10'(FLINE))) pos_err++;
        end
        if (move) move_hi++;
        if (unbreak && !prev_ub) begin ub_pulses++; last_x = spawn_x; end
        prev_move = move; prev_ub = unbreak;
        if (pixpulse) begin
            if (hcount == 10'(HMAX)) begin
                hcount = 10'd0;
                vcount = (vcount == 10'(VMAX)) ? 10'(VMIN) : vcount + 10'd1;
            end else hcount = hcount + 10'd1;
        end
        pixpulse = ~pixpulse;
    endtask

    task automatic do_reset();
        rst = 1'b0; broken = 1'b0; inc_score = 1'b0; game_over = 1'b0;
        pixpulse = 1'b0; hcount = 10'd0; vcount = 10'(VMIN);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Step until the next edge will see pixpulse=1 at (h, v).
    task automatic align(input int h, input int v);
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (pixpulse && hcount == 10'(h) && vcount == 10'(v)) found = 1;
            else step();
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL align: no sweep position %0d/%0d", h, v); end
    endtask

    task automatic check_clean(input string name);
        tests_run++;
        if (move_err !== 0 || ub_err !== 0 || x_err !== 0 || pos_err !== 0) begin
            tests_failed++;
            $display("FAIL %s strobes: move_err=%0d ub_err=%0d x_err=%0d pos_err=%0d expected all 0",
                     name, move_err, ub_err, x_err, pos_err);
        end
    endtask

    task automatic wait_spawn_entry(input string name);
        for (int i = 0; i < 3000 && m_st != 2; i++) step();
        tests_run++;
        if (m_st != 2) begin tests_failed++; $display("FAIL %s: countdown never expired", name); end
    endtask

    task automatic wait_unbreak(input string name);
        for (int i = 0; i < 3000 && ub_pulses == 0; i++) step();
        repeat (4) step();
        tests_run++;
        if (ub_pulses !== 1) begin
            tests_failed++; $display("FAIL %s unbreak count: got %0d expected 1", name, ub_pulses);
        end
        tests_run++;
        if (last_x < 10'(XLO) || last_x > 10'(XHI)) begin
            tests_failed++; $display("FAIL %s spawn_x range: got %0d expected 40..600", name, last_x);
        end
    endtask

    task automatic inc_pulse(input int hi_steps);
        inc_score = 1'b1; repeat (hi_steps) step();
        inc_score = 1'b0; repeat (4) step();
    endtask

    task automatic check_score(input string name, input int s, input int l);
        tests_run++;
        if (score !== 8'(s) || speed_level !== 3'(l)) begin
            tests_failed++;
            $display("FAIL %s: score=%0d level=%0d expected score=%0d level=%0d", name, score, speed_level, s, l);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (move !== 1'b0 || unbreak !== 1'b0 || spawn_valid !== 1'b0 || spawn_x !== 10'd40 ||
            score !== 8'd0 || speed_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_values: move=%0b unbreak=%0b valid=%0b x=%0d score=%0d level=%0d expected 0 0 0 40 0 0",
                     move, unbreak, spawn_valid, spawn_x, score, speed_level);
        end
        do_reset();
    endtask

    task automatic test_frames();
        clear_stats();
        repeat (384) step();
        tests_run++;
        if (move_rises !== 3) begin tests_failed++; $display("FAIL frame_ticks: got %0d expected 3", move_rises); end
        tests_run++;
        if (move_hi !== 6) begin tests_failed++; $display("FAIL move_width: got %0d clk expected 6", move_hi); end
        tests_run++;
        if (ub_pulses !== 0) begin tests_failed++; $display("FAIL idle_unbreak: got %0d expected 0", ub_pulses); end
        check_clean("frames");
    endtask

    task automatic test_spawn();
        align(3, 477);
        broken = 1'b1;
        clear_stats();
        wait_spawn_entry("spawn");
        tests_run++;
        if (move_rises !== 3) begin tests_failed++; $display("FAIL spawn_ticks: got %0d expected 3", move_rises); end
        wait_unbreak("spawn");
        check_clean("spawn");
        broken = 1'b0; repeat (4) step();
    endtask

    task automatic test_simultaneous();
        align(0, FLINE);
        broken = 1'b1;
        clear_stats();
        wait_spawn_entry("simul");
        tests_run++;
        if (move_rises !== 4) begin tests_failed++; $display("FAIL simul_ticks: got %0d expected 4", move_rises); end
        wait_unbreak("simul");
        check_clean("simul");
        broken = 1'b0; repeat (4) step();
    endtask

    task automatic test_retry();
        bit found = 0;
        align(3, 477);
        broken = 1'b1;
        clear_stats();
        wait_spawn_entry("retry");
        game_over = 1'b1;
        for (int i = 0; i < 2200 && !found; i++) begin
            if (pixpulse && m_lfsr == 10'd700) found = 1;
            else step();
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL retry_setup: lfsr never reached 700"); end
        game_over = 1'b0;
        step();
        tests_run++;
        if (unbreak !== 1'b0 || spawn_valid !== 1'b0) begin
            tests_failed++; $display("FAIL retry_reject: unbreak=%0b valid=%0b expected 0 0", unbreak, spawn_valid);
        end
        tests_run++;
        if (retries < 1) begin tests_failed++; $display("FAIL retry_count: got %0d expected >=1", retries); end
        wait_unbreak("retry");
        check_clean("retry");
        broken = 1'b0; repeat (4) step();
    endtask

    task automatic test_game_over();
        align(3, 477);
        broken = 1'b1;
        for (int i = 0; i < 400 && !(m_st == 1 && m_cnt == RF - 1); i++) step();
        game_over = 1'b1;
        clear_stats();
        repeat (400) step();
        tests_run++;
        if (move_rises !== 0 || ub_pulses !== 0) begin
            tests_failed++; $display("FAIL frozen: moves=%0d unbreaks=%0d expected 0 0", move_rises, ub_pulses);
        end
        game_over = 1'b0;
        clear_stats();
        wait_spawn_entry("resume");
        tests_run++;
        if (move_rises !== RF - 1) begin
            tests_failed++; $display("FAIL resume_ticks: got %0d expected %0d", move_rises, RF - 1);
        end
        wait_unbreak("resume");
        check_clean("game_over");
        broken = 1'b0; repeat (4) step();
    endtask

    task automatic test_midreset();
        inc_pulse(4);
        check_score("pre_reset_score", 1, 0);
        align(3, 477);
        broken = 1'b1;
        for (int i = 0; i < 400 && !(move && m_st == 1); i++) step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (move !== 1'b0 || unbreak !== 1'b0 || spawn_valid !== 1'b0 || spawn_x !== 10'd40 ||
            score !== 8'd0 || speed_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL midreset: move=%0b unbreak=%0b valid=%0b x=%0d score=%0d level=%0d expected 0 0 0 40 0 0",
                     move, unbreak, spawn_valid, spawn_x, score, speed_level);
        end
        do_reset();
        clear_stats();
        repeat (200) step();
        tests_run++;
        if (ub_pulses !== 0) begin tests_failed++; $display("FAIL post_reset_unbreak: got %0d expected 0", ub_pulses); end
        check_clean("midreset");
    endtask

    task automatic test_score();
        do_reset();
        repeat (7) inc_pulse(4);
        check_score("score7", 7, 0);
        inc_pulse(4);
        check_score("score8", 8, 1);
        inc_pulse(100);
        check_score("held_high", 9, 1);
        game_over = 1'b1;
        inc_pulse(4);
        game_over = 1'b0;
        repeat (2) step();
        check_score("frozen_score", 9, 1);
    endtask

    task automatic test_saturation();
        repeat (55) inc_pulse(4);
        check_score("score64", 64, 7);
        repeat (191) inc_pulse(4);
        check_score("score255", 255, 7);
        inc_pulse(4);
        check_score("score_sat", 255, 7);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        model_reset();
        test_reset();
        test_frames();
        test_spawn();
        test_simultaneous();
        test_retry();
        test_game_over();
        test_midreset();
        test_score();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
